// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master side issues operands and a start request; the slave side
// reports busy/done and presents the held result.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit per clock,
// LSB first, with its carry registered and fed back into the next bit.
// Latency is WIDTH cycles of SHIFT plus a one-cycle DONE pulse; the result
// and carry-out are held in output registers until the next completion.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_serial_adder_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    // Full-adder cell on the current LSBs and the fed-back carry.
    assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    // NOTE: the default assignment first keeps this block free of latches
    // on any path the case statement does not cover.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Serial datapath: capture operands on accept, shift one bit per SHIFT
    // edge, and publish sum/cout only on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_q  <= {fa_sum, s_sr[WIDTH-1:1]};
                        cout_q <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from the state, plus the held result registers.
    assign bus.busy = (state == ST_SHIFT);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder with hand-computed expected results.
module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bit_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One full operation: accept, measure latency and busy width, check result.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] es, input logic ec, input string tag);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bus.a     = ta;
        bus.b     = tb_v;
        bus.cin   = tc;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_v;
        bus.cin   = ~tc;
        lat      = 0;
        busy_cnt = bus.busy ? 1 : 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) lat = i;
            else if (bus.busy) busy_cnt++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_sum"}, bus.sum, es);
        check({tag, "_cout"}, bus.cout, ec);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, bus.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int lat;
        int prev;
        int unstable;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Power-on reset state.
        #12;
        check("por_busy", bus.busy, 0);
        check("por_done", bus.done, 0);
        check("por_sum", bus.sum, 0);
        check("por_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add and carry-propagation vectors.
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "add_cin_only");

        // Asynchronous reset asserted mid-cycle clears outputs at once.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_done", bus.done, 0);
        check("async_rst_sum", bus.sum, 0);
        check("async_rst_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // start pulsed during SHIFT with new operands is ignored.
        @(negedge clk);
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0;
        lat    = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3 || i == 4) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        check("ignore_start_pulses", pulses, 1);
        check("ignore_start_latency", lat, 8);
        check("ignore_start_sum", bus.sum, 8'h30);
        check("ignore_start_cout", bus.cout, 0);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        pulses   = 0;
        prev     = 0;
        unstable = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                if (prev != 0) check("thru_gap", i - prev, 10);
                else check("thru_first_latency", i, 9);
                prev = i;
                check("thru_sum", bus.sum, 8'h02);
            end
            if (pulses > 0 && (bus.sum !== 8'h02 || bus.cout !== 1'b0)) unstable++;
        end
        check("thru_pulses", pulses, 4);
        check("thru_stable", unstable, 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(posedge clk);

        // Reset four cycles into SHIFT discards the operation.
        @(negedge clk);
        bus.a     = 8'h33;
        bus.b     = 8'h44;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midshift_rst_busy", bus.busy, 0);
        check("midshift_rst_done", bus.done, 0);
        check("midshift_rst_sum", bus.sum, 0);
        check("midshift_rst_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("midshift_no_done", pulses, 0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "after_rst_80_80");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
